// File: rtl/param_fifo_ctl.sv
// Single-clock parametrised FIFO controller with show-ahead/registered read,
// runtime almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module param_fifo_ctl #(
    parameter int WIDTH_DATA = 8,
    parameter int NUMWORDS   = 16,
    parameter int SHOWAHEAD  = 0,
    parameter int _WIDTH_UW  = $clog2(NUMWORDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH_DATA-1:0] wr_data,
    input  logic                  rd_en,
    output logic [WIDTH_DATA-1:0] rd_data,
    input  logic [_WIDTH_UW-1:0]  af_thresh,
    input  logic [_WIDTH_UW-1:0]  ae_thresh,
    input  logic                  err_clr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [_WIDTH_UW-1:0]  usedw
);
    localparam int                   AW    = $clog2(NUMWORDS);
    localparam logic [AW-1:0]        LAST  = AW'(NUMWORDS - 1);
    localparam logic [_WIDTH_UW-1:0] DEPTH = _WIDTH_UW'(NUMWORDS);

    logic [WIDTH_DATA-1:0] mem [NUMWORDS];
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full         = (usedw == DEPTH);
    assign empty        = (usedw == '0);
    assign almost_full  = (usedw >= af_thresh);
    assign almost_empty = (usedw <= ae_thresh);

    // Flush swallows the same-cycle requests entirely, so it also masks the error sets.
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            usedw     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_addr <= '0;
                rd_addr <= '0;
                usedw   <= '0;
            end else begin
                // Explicit wrap keeps non-power-of-2 depths inside the array.
                if (wr_acc)
                    wr_addr <= (wr_addr == LAST) ? '0 : wr_addr + AW'(1);
                if (rd_acc)
                    rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + AW'(1);
                if (wr_acc && !rd_acc)
                    usedw <= usedw + _WIDTH_UW'(1);
                else if (rd_acc && !wr_acc)
                    usedw <= usedw - _WIDTH_UW'(1);
            end
            if (wr_en && full && !flush)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (rd_en && empty && !flush)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_addr] <= wr_data;
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign rd_data = empty ? '0 : mem[rd_addr];
        end else begin : g_registered
            always_ff @(posedge clk) begin
                if (!rst_n)
                    rd_data <= '0;
                else if (rd_acc)
                    rd_data <= mem[rd_addr];
            end
        end
    endgenerate

endmodule

// File: tb/tb_param_fifo_ctl.sv
// Bench for param_fifo_ctl: a 16-deep registered-read FIFO and a 5-deep show-ahead FIFO
// driven with the same stimulus and compared against a queue-based reference model.
module tb_param_fifo_ctl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [4:0] af0 = 5'd12, ae0 = 5'd3;
    logic [2:0] af1 = 3'd4, ae1 = 3'd1;

    logic [7:0] rd_data0, rd_data1;
    logic       full0, empty0, afl0, ael0, ov0, un0;
    logic       full1, empty1, afl1, ael1, ov1, un1;
    logic [4:0] uw0;
    logic [2:0] uw1;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    bit         mov[2];
    bit         mun[2];
    logic [7:0] mrd[2];

    always #5 clk = ~clk;

    param_fifo_ctl #(.WIDTH_DATA(8), .NUMWORDS(16), .SHOWAHEAD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data0), .af_thresh(af0), .ae_thresh(ae0),
        .err_clr(err_clr), .full(full0), .empty(empty0), .almost_full(afl0),
        .almost_empty(ael0), .overflow(ov0), .underflow(un0), .usedw(uw0));

    param_fifo_ctl #(.WIDTH_DATA(8), .NUMWORDS(5), .SHOWAHEAD(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data1), .af_thresh(af1), .ae_thresh(ae1),
        .err_clr(err_clr), .full(full1), .empty(empty1), .almost_full(afl1),
        .almost_empty(ael1), .overflow(ov1), .underflow(un1), .usedw(uw1));

    function automatic int msize(input int d);
        return (d == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [7:0] mhead1();
        return (mq1.size() != 0) ? mq1[0] : 8'h00;
    endfunction

    // Reference model: occupancy is a queue, errors are plain booleans.
    task automatic mstep(input bit r, input bit f, input bit w, input logic [7:0] wd,
                         input bit rd, input bit clr);
        for (int d = 0; d < 2; d++) begin
            logic [7:0] q[$];
            int  n;
            bit  fu, em;
            n = (d == 0) ? 16 : 5;
            if (d == 0) q = mq0; else q = mq1;
            if (!r) begin
                q.delete();
                mov[d] = 1'b0;
                mun[d] = 1'b0;
                mrd[d] = 8'h00;
            end else begin
                fu = (q.size() == n);
                em = (q.size() == 0);
                mov[d] = (!f && w && fu) || (mov[d] && !clr);
                mun[d] = (!f && rd && em) || (mun[d] && !clr);
                if (f) begin
                    q.delete();
                end else begin
                    if (rd && !em) mrd[d] = q.pop_front();
                    if (w && !fu) q.push_back(wd);
                end
            end
            if (d == 0) mq0 = q; else mq1 = q;
        end
    endtask

    task automatic cyc(input bit r, input bit f, input bit w, input logic [7:0] wd,
                       input bit rd, input bit clr);
        rst_n = r; flush = f; wr_en = w; wr_data = wd; rd_en = rd; err_clr = clr;
        @(posedge clk);
        mstep(r, f, w, wd, rd, clr);
        #1;
        rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d); cyc(1, 0, 1, d, 0, 0); endtask
    task automatic rdc();                   cyc(1, 0, 0, 8'h00, 1, 0); endtask
    task automatic rst_cyc();               cyc(0, 0, 0, 8'h00, 0, 0); endtask

    task automatic test_reset();
        cyc(0, 1, 1, 8'h99, 1, 1);
        checks++; if (uw0 !== 5'd0) begin errors++; $display("FAIL reset_usedw got %0d want 0", uw0); end
        checks++; if ({empty0, full0} !== 2'b10) begin errors++; $display("FAIL reset_empty_full got %b want 10", {empty0, full0}); end
        checks++; if ({ov0, un0, ov1, un1} !== 4'b0) begin errors++; $display("FAIL reset_errs got %b want 0000", {ov0, un0, ov1, un1}); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data0); end
        checks++; if ({uw1, empty1, rd_data1} !== {3'd0, 1'b1, 8'h00}) begin errors++; $display("FAIL reset_sa got %h/%b/%h want 0/1/00", uw1, empty1, rd_data1); end
    endtask

    task automatic test_fill_drain();
        rst_cyc();
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
            checks++; if (uw0 !== 5'(i)) begin errors++; $display("FAIL fill_usedw got %0d want %0d", uw0, i); end
        end
        checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full0); end
        for (int i = 1; i <= 16; i++) begin
            rdc();
            checks++; if (rd_data0 !== 8'(i)) begin errors++; $display("FAIL drain_data got %h want %h", rd_data0, 8'(i)); end
        end
        checks++; if ({empty0, ov0, un0} !== 3'b100) begin errors++; $display("FAIL drain_end got %b want 100", {empty0, ov0, un0}); end
    endtask

    task automatic test_overflow();
        rst_cyc();
        for (int i = 1; i <= 16; i++) wr(8'(i));
        cyc(1, 0, 1, 8'hAA, 1, 0);
        checks++; if (uw0 !== 5'd15) begin errors++; $display("FAIL ovf_usedw got %0d want 15", uw0); end
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ov0); end
        checks++; if (rd_data0 !== 8'h01) begin errors++; $display("FAIL ovf_rd got %h want 01", rd_data0); end
        cyc(1, 0, 0, 8'h00, 0, 1);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ov0); end
        for (int i = 2; i <= 16; i++) begin
            rdc();
            checks++; if (rd_data0 !== 8'(i)) begin errors++; $display("FAIL ovf_drain got %h want %h", rd_data0, 8'(i)); end
        end
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b want 1", empty0); end
    endtask

    task automatic test_wrap();
        rst_cyc();
        for (int r = 1; r <= 3; r++) begin
            for (int i = 0; i < 4; i++) wr(8'(16 * r + i));
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (empty1 !== 1'b0 || rd_data1 !== 8'(16 * r + i)) begin
                    errors++; $display("FAIL wrap_head got %h/e%b want %h/e0", rd_data1, empty1, 8'(16 * r + i));
                end
                rdc();
            end
            checks++; if ({empty1, rd_data1} !== {1'b1, 8'h00}) begin errors++; $display("FAIL wrap_empty got %b/%h want 1/00", empty1, rd_data1); end
        end
    endtask

    task automatic test_thresholds();
        rst_cyc();
        af0 = 5'd12; ae0 = 5'd3;
        for (int lvl = 0; lvl <= 16; lvl++) begin
            if (lvl == 10) begin
                af0 = 5'd8; #1;
                checks++; if (afl0 !== 1'b1) begin errors++; $display("FAIL thr_af_change got %b want 1", afl0); end
            end
            checks++; if (ael0 !== (lvl <= 3)) begin errors++; $display("FAIL thr_ae lvl %0d got %b", lvl, ael0); end
            checks++; if (afl0 !== (lvl >= ((lvl < 10) ? 12 : 8))) begin errors++; $display("FAIL thr_af lvl %0d got %b", lvl, afl0); end
            if (lvl < 16) wr(8'(lvl));
        end
        ae0 = 5'd16; #1;
        checks++; if (ael0 !== 1'b1) begin errors++; $display("FAIL thr_ae_max got %b want 1", ael0); end
        rst_cyc();
        af0 = 5'd0; #1;
        checks++; if (afl0 !== 1'b1) begin errors++; $display("FAIL thr_af_zero got %b want 1", afl0); end
        af0 = 5'd12; ae0 = 5'd3;
    endtask

    task automatic test_flush();
        rst_cyc();
        for (int i = 0; i < 7; i++) wr(8'h40 + 8'(i));
        rdc(); rdc();
        cyc(1, 1, 1, 8'h77, 1, 0);
        checks++; if ({uw0, empty0} !== {5'd0, 1'b1}) begin errors++; $display("FAIL flush_state got %0d/%b want 0/1", uw0, empty0); end
        checks++; if (rd_data0 !== 8'h41) begin errors++; $display("FAIL flush_rd_hold got %h want 41", rd_data0); end
        checks++; if ({ov0, un0, ov1, un1} !== 4'b0010) begin errors++; $display("FAIL flush_errs got %b want 0010", {ov0, un0, ov1, un1}); end
        cyc(1, 0, 0, 8'h00, 0, 0);
        checks++; if ({uw0, uw1} !== 8'd0) begin errors++; $display("FAIL flush_noacc got %0d/%0d want 0/0", uw0, uw1); end
    endtask

    task automatic test_underflow_reset();
        rst_cyc();
        rdc();
        checks++; if ({un0, uw0} !== {1'b1, 5'd0}) begin errors++; $display("FAIL udf got %b/%0d want 1/0", un0, uw0); end
        for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
        rdc();
        cyc(0, 0, 1, 8'hEE, 1, 0);
        checks++; if ({uw0, empty0, un0, ov0} !== {5'd0, 3'b100}) begin errors++; $display("FAIL midrst_state got %0d/%b%b%b", uw0, empty0, un0, ov0); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL midrst_rd got %h want 00", rd_data0); end
        wr(8'h5C);
        checks++; if (rd_data1 !== 8'h5C) begin errors++; $display("FAIL post_rst_sa got %h want 5c", rd_data1); end
        rdc();
        checks++; if (rd_data0 !== 8'h5C) begin errors++; $display("FAIL post_rst_rd got %h want 5c", rd_data0); end
    endtask

    task automatic test_random();
        logic [18:0] e0, g0;
        logic [16:0] e1, g1;
        rst_cyc();
        for (int n = 0; n < 800; n++) begin
            int wp;
            wp = ((n / 60) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 15) == 0) begin
                af0 = 5'($urandom_range(0, 20)); ae0 = 5'($urandom_range(0, 20));
                af1 = 3'($urandom_range(0, 7));  ae1 = 3'($urandom_range(0, 7));
            end
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) >= wp,
                $urandom_range(0, 19) == 0);
            e0 = {5'(msize(0)), msize(0) == 16, msize(0) == 0, msize(0) >= int'(af0),
                  msize(0) <= int'(ae0), mov[0], mun[0], mrd[0]};
            g0 = {uw0, full0, empty0, afl0, ael0, ov0, un0, rd_data0};
            checks++; if (g0 !== e0) begin errors++; $display("FAIL rand_dut0 cyc %0d got %h want %h", n, g0, e0); end
            e1 = {3'(msize(1)), msize(1) == 5, msize(1) == 0, msize(1) >= int'(af1),
                  msize(1) <= int'(ae1), mov[1], mun[1], mhead1()};
            g1 = {uw1, full1, empty1, afl1, ael1, ov1, un1, rd_data1};
            checks++; if (g1 !== e1) begin errors++; $display("FAIL rand_dut1 cyc %0d got %h want %h", n, g1, e1); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_thresholds();
        test_flush();
        test_underflow_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
